// File: rtl/fp32_serial_addsub_alu_pkg.sv
// Shared definitions for the byte-serial FP32 add/subtract unit:
// state encoding, IEEE-754 single-precision constants and a small
// leading-zero-count helper used by the normaliser.
package fp32_serial_addsub_alu_pkg;

    // Field widths of an IEEE-754 single-precision word.
    localparam int SIGN_W = 1;
    localparam int EXP_W  = 8;
    localparam int FRAC_W = 23;

    // Floating-point constants.
    localparam logic [7:0]  EXP_BIAS = 8'd127;
    localparam logic [7:0]  EXP_MAX  = 8'hFF;
    localparam logic [31:0] QNAN     = 32'h7FC0_0000;
    localparam logic [31:0] POS_ZERO = 32'h0000_0000;

    // Transaction states. Codes 14 and 15 are unused and recover to IDLE.
    typedef enum logic [3:0] {
        ST_IDLE = 4'd0,
        ST_A3   = 4'd1,
        ST_A2   = 4'd2,
        ST_A1   = 4'd3,
        ST_A0   = 4'd4,
        ST_B3   = 4'd5,
        ST_B2   = 4'd6,
        ST_B1   = 4'd7,
        ST_B0   = 4'd8,
        ST_CALC = 4'd9,
        ST_O3   = 4'd10,
        ST_O2   = 4'd11,
        ST_O1   = 4'd12,
        ST_O0   = 4'd13
    } state_t;

    // Leading-zero count of a 27-bit value; returns 27 for an all-zero input.
    function automatic logic [4:0] lzc27(input logic [26:0] v);
        logic [4:0] n;
        n = 5'd27;
        for (int i = 0; i < 27; i++) begin
            if (v[i]) n = 5'(26 - i);
        end
        return n;
    endfunction

endpackage

// File: rtl/fp32_addsub_core.sv
// Combinational IEEE-754 single-precision add/subtract.
// Denormals read as signed zero, tiny results flush to signed zero,
// overflow saturates to infinity, all NaNs collapse to the canonical
// quiet NaN, rounding is round-to-nearest-even.
module fp32_addsub_core
    import fp32_serial_addsub_alu_pkg::*;
(
    input  logic [31:0] a,
    input  logic [31:0] b,
    input  logic        sub,
    output logic [31:0] result
);

    // Unpacked fields; b carries its effective sign once sub is applied.
    logic              sa, sb;
    logic [EXP_W-1:0]  ea, eb;
    logic [FRAC_W-1:0] fa, fb;
    logic              a_nan, b_nan, a_inf, b_inf, a_zero, b_zero;

    assign sa = a[31];
    assign sb = b[31] ^ sub;
    assign ea = a[30:23];
    assign eb = b[30:23];
    assign fa = a[22:0];
    assign fb = b[22:0];

    assign a_nan  = (ea == EXP_MAX) && (fa != '0);
    assign b_nan  = (eb == EXP_MAX) && (fb != '0);
    assign a_inf  = (ea == EXP_MAX) && (fa == '0);
    assign b_inf  = (eb == EXP_MAX) && (fb == '0);
    assign a_zero = (ea == 8'd0);
    assign b_zero = (eb == 8'd0);

    // Order operands so x has the larger magnitude; y is the one aligned.
    logic              swap;
    logic              sx, sy;
    logic [EXP_W-1:0]  ex, ey;
    logic [23:0]       mx, my;

    assign swap = (b[30:0] > a[30:0]);
    assign sx   = swap ? sb : sa;
    assign sy   = swap ? sa : sb;
    assign ex   = swap ? eb : ea;
    assign ey   = swap ? ea : eb;
    assign mx   = {1'b1, (swap ? fb : fa)};
    assign my   = {1'b1, (swap ? fa : fb)};

    // Alignment keeps two extra bits (guard, round) plus a sticky bit.
    logic [7:0]  dexp;
    logic [49:0] y_sh;
    logic [26:0] x_ext, y_ext;

    assign dexp  = ex - ey;
    assign y_sh  = {my, 26'd0} >> dexp;
    assign y_ext = (dexp > 8'd26) ? 27'd1 : {y_sh[49:24], |y_sh[23:0]};
    assign x_ext = {mx, 3'b000};

    // Magnitude add or subtract; bit 27 is the carry-out of an addition.
    logic        eff_sub;
    logic [27:0] sum;
    logic        carry;
    logic [4:0]  lz;
    logic [26:0] norm;
    logic [9:0]  e_norm, e_fin;
    logic        round_up;
    logic [24:0] mr;
    logic [22:0] frac;
    logic        underflow, overflow;

    assign eff_sub = sx ^ sy;
    assign sum     = eff_sub ? ({1'b0, x_ext} - {1'b0, y_ext})
                             : ({1'b0, x_ext} + {1'b0, y_ext});
    assign carry   = sum[27];
    // A carry renormalises right; otherwise cancellation shifts left.
    assign lz      = carry ? 5'd0 : lzc27(sum[26:0]);
    assign norm    = carry ? {sum[27:2], sum[1] | sum[0]} : (sum[26:0] << lz);
    assign e_norm  = {2'b00, ex} + {9'd0, carry} - {5'd0, lz};

    // Round to nearest, ties to even, on guard/round/sticky.
    assign round_up = norm[2] & (norm[1] | norm[0] | norm[3]);
    assign mr       = {1'b0, norm[26:3]} + {24'd0, round_up};
    assign e_fin    = e_norm + {9'd0, mr[24]};
    // Rounding overflow leaves the hidden bit clear and the fraction zero.
    assign frac     = mr[23] ? mr[22:0] : 23'd0;

    assign underflow = e_norm[9] || (e_norm == 10'd0);
    assign overflow  = !e_fin[9] && (e_fin[8:0] >= 9'd255);

    // Result selection: special cases first, then the normalised path.
    always_comb begin
        result = {sx, e_fin[7:0], frac};
        if (a_nan || b_nan) begin
            result = QNAN;
        end else if (a_inf && b_inf) begin
            result = (sa != sb) ? QNAN : {sa, EXP_MAX, 23'd0};
        end else if (a_inf) begin
            result = {sa, EXP_MAX, 23'd0};
        end else if (b_inf) begin
            result = {sb, EXP_MAX, 23'd0};
        end else if (a_zero && b_zero) begin
            result = {sa & sb, 31'd0};
        end else if (a_zero) begin
            result = {sb, b[30:0]};
        end else if (b_zero) begin
            result = a;
        end else if (sum == 28'd0) begin
            result = POS_ZERO;
        end else if (underflow) begin
            result = {sx, 31'd0};
        end else if (overflow) begin
            result = {sx, EXP_MAX, 23'd0};
        end
    end

endmodule

// File: rtl/fp32_serial_addsub_alu.sv
// Byte-serial FP32 add/subtract ALU: loads a then b MSB-first over an
// 8-bit bus, computes in one cycle, then streams the result MSB-first
// with done high.
//
// Request semantics: start is sampled only in IDLE; opcode is captured on
// that same edge. Once accepted, the next eight edges take one operand
// byte each from `in` unconditionally (no valid/ready stall), and four
// result bytes follow, one per cycle, qualified by done.
module fp32_serial_addsub_alu
    import fp32_serial_addsub_alu_pkg::*;
(
    input  logic       clk,
    input  logic       rst_n,
    input  logic [7:0] in,
    input  logic       opcode,
    input  logic       start,
    output logic [7:0] out,
    output logic       done,
    output logic [3:0] state_out
);

    state_t      state, next_state;
    logic [31:0] a_reg, b_reg, res_reg;
    logic        op_reg;
    logic [31:0] core_result;

    fp32_addsub_core u_core (
        .a      (a_reg),
        .b      (b_reg),
        .sub    (op_reg),
        .result (core_result)
    );

    // State register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state <= ST_IDLE;
        else        state <= next_state;
    end

    // Next-state sequencing through load, compute and stream phases.
    always_comb begin
        next_state = ST_IDLE;
        case (state)
            ST_IDLE: next_state = start ? ST_A3 : ST_IDLE;
            ST_A3:   next_state = ST_A2;
            ST_A2:   next_state = ST_A1;
            ST_A1:   next_state = ST_A0;
            ST_A0:   next_state = ST_B3;
            ST_B3:   next_state = ST_B2;
            ST_B2:   next_state = ST_B1;
            ST_B1:   next_state = ST_B0;
            ST_B0:   next_state = ST_CALC;
            ST_CALC: next_state = ST_O3;
            ST_O3:   next_state = ST_O2;
            ST_O2:   next_state = ST_O1;
            ST_O1:   next_state = ST_O0;
            ST_O0:   next_state = ST_IDLE;
            default: next_state = ST_IDLE;
        endcase
    end

    // Operand capture, opcode latch and result register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            a_reg   <= '0;
            b_reg   <= '0;
            res_reg <= '0;
            op_reg  <= 1'b0;
        end else begin
            case (state)
                ST_IDLE: if (start) op_reg <= opcode;
                ST_A3:   a_reg[31:24] <= in;
                ST_A2:   a_reg[23:16] <= in;
                ST_A1:   a_reg[15:8]  <= in;
                ST_A0:   a_reg[7:0]   <= in;
                ST_B3:   b_reg[31:24] <= in;
                ST_B2:   b_reg[23:16] <= in;
                ST_B1:   b_reg[15:8]  <= in;
                ST_B0:   b_reg[7:0]   <= in;
                ST_CALC: res_reg <= core_result;
                default: ;
            endcase
        end
    end

    // Output byte mux decoded from the registered state only.
    always_comb begin
        out  = 8'h00;
        done = 1'b0;
        case (state)
            ST_O3: begin out = res_reg[31:24]; done = 1'b1; end
            ST_O2: begin out = res_reg[23:16]; done = 1'b1; end
            ST_O1: begin out = res_reg[15:8];  done = 1'b1; end
            ST_O0: begin out = res_reg[7:0];   done = 1'b1; end
            default: ;
        endcase
    end

    assign state_out = state;

endmodule

// File: tb/tb_fp32_serial_addsub_alu.sv
// Directed bench for the byte-serial FP32 add/subtract ALU. Expected
// results are hand-derived constants queued when an operation is issued
// and popped when its four result bytes have been collected.
module tb_fp32_serial_addsub_alu;

    logic       clk;
    logic       rst_n;
    logic [7:0] in;
    logic       opcode;
    logic       start;
    logic [7:0] out;
    logic       done;
    logic [3:0] state_out;

    int tests_run    = 0;
    int tests_failed = 0;

    logic [31:0] exp_q[$];

    fp32_serial_addsub_alu dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .in        (in),
        .opcode    (opcode),
        .start     (start),
        .out       (out),
        .done      (done),
        .state_out (state_out)
    );

    // Clock
    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] expv);
        tests_run++;
        assert (obs === expv) else begin
            tests_failed++;
            $error("FAIL %s: got %08h, expected %08h", tag, obs, expv);
        end
    endtask

    // One complete transaction. Inputs change on the falling edge; outputs
    // are sampled there too, half a cycle away from the active edge.
    task automatic run_op(input logic [31:0] a, input logic [31:0] b, input logic op,
                          input logic [31:0] expv, input bit hold_start,
                          input bit pulse_b3, input string name);
        logic [63:0] ops;
        logic [31:0] got;
        logic [31:0] want;
        ops = {a, b};
        got = '0;
        exp_q.push_back(expv);
        @(negedge clk);
        check({name, " idle"}, {28'd0, state_out}, 32'd0);
        start  = 1'b1;
        opcode = op;
        in     = 8'($urandom_range(0, 255));
        for (int i = 0; i < 8; i++) begin
            @(negedge clk);
            check($sformatf("%s load st%0d", name, i + 1), {28'd0, state_out}, 32'(i + 1));
            check($sformatf("%s load done%0d", name, i + 1), {31'd0, done}, 32'd0);
            in     = ops[63 - 8*i -: 8];
            start  = hold_start || (pulse_b3 && (i == 4));
            opcode = 1'($urandom_range(0, 1));
        end
        @(negedge clk);
        check({name, " calc"}, {28'd0, state_out}, 32'd9);
        check({name, " calc out"}, {24'd0, out}, 32'd0);
        in = 8'($urandom_range(0, 255));
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            check($sformatf("%s out st%0d", name, 10 + i), {28'd0, state_out}, 32'(10 + i));
            check($sformatf("%s out done%0d", name, 10 + i), {31'd0, done}, 32'd1);
            got[31 - 8*i -: 8] = out;
        end
        @(negedge clk);
        start = 1'b0;
        check({name, " end st"}, {28'd0, state_out}, 32'd0);
        check({name, " end done"}, {31'd0, done}, 32'd0);
        check({name, " end out"}, {24'd0, out}, 32'd0);
        want = exp_q.pop_front();
        check({name, " result"}, got, want);
    endtask

    // Starts a 1.0+2.0 load, then asserts reset asynchronously mid-cycle
    // when the given state is reached.
    task automatic abort_op(input logic [3:0] abort_state, input string name);
        logic [63:0] ops;
        bit          reached;
        ops     = {32'h3F80_0000, 32'h4000_0000};
        reached = 1'b0;
        @(negedge clk);
        start  = 1'b1;
        opcode = 1'b0;
        for (int c = 0; c < 20; c++) begin
            @(negedge clk);
            start = 1'b0;
            if (c < 8) in = ops[63 - 8*c -: 8];
            else       in = 8'h00;
            if (state_out == abort_state) begin
                reached = 1'b1;
                break;
            end
        end
        check({name, " reached"}, {31'd0, reached}, 32'd1);
        #2 rst_n = 1'b0;
        #1;
        check({name, " rst st"}, {28'd0, state_out}, 32'd0);
        check({name, " rst done"}, {31'd0, done}, 32'd0);
        check({name, " rst out"}, {24'd0, out}, 32'd0);
        @(negedge clk);
        rst_n = 1'b1;
        in    = 8'h00;
    endtask

    initial begin
        rst_n  = 1'b0;
        start  = 1'b0;
        opcode = 1'b0;
        in     = 8'h00;
        repeat (3) @(negedge clk);
        check("reset st", {28'd0, state_out}, 32'd0);
        check("reset done", {31'd0, done}, 32'd0);
        check("reset out", {24'd0, out}, 32'd0);
        rst_n = 1'b1;

        run_op(32'h3F80_0000, 32'h4000_0000, 1'b0, 32'h4040_0000, 1'b0, 1'b0, "1+2");
        run_op(32'h40A0_0000, 32'h4040_0000, 1'b1, 32'h4000_0000, 1'b0, 1'b0, "5-3");
        run_op(32'h3F80_0000, 32'h3F80_0000, 1'b1, 32'h0000_0000, 1'b0, 1'b0, "1-1");
        run_op(32'h7F80_0000, 32'h7F80_0000, 1'b1, 32'h7FC0_0000, 1'b0, 1'b0, "inf-inf");
        run_op(32'h7F7F_FFFF, 32'h7F7F_FFFF, 1'b0, 32'h7F80_0000, 1'b0, 1'b0, "ovf");
        run_op(32'h7FC0_0001, 32'h3F80_0000, 1'b0, 32'h7FC0_0000, 1'b0, 1'b0, "nan");
        run_op(32'h0000_0001, 32'h0000_0000, 1'b0, 32'h0000_0000, 1'b0, 1'b0, "denorm");
        run_op(32'h3F80_0000, 32'h3380_0000, 1'b0, 32'h3F80_0000, 1'b0, 1'b0, "tie even");
        run_op(32'h3F80_0001, 32'h3380_0000, 1'b0, 32'h3F80_0002, 1'b0, 1'b0, "tie odd");
        run_op(32'h3F80_0000, 32'h33C0_0000, 1'b0, 32'h3F80_0001, 1'b0, 1'b0, "above tie");
        run_op(32'hBFC0_0000, 32'h3F00_0000, 1'b0, 32'hBF80_0000, 1'b0, 1'b0, "neg sum");
        run_op(32'h3F80_0001, 32'h3F80_0000, 1'b1, 32'h3400_0000, 1'b0, 1'b0, "cancel");
        run_op(32'h8000_0000, 32'h8000_0000, 1'b0, 32'h8000_0000, 1'b0, 1'b0, "-0+-0");
        run_op(32'h0000_0000, 32'h0000_0000, 1'b1, 32'h0000_0000, 1'b0, 1'b0, "+0-+0");
        run_op(32'h3F80_0000, 32'h7F80_0000, 1'b1, 32'hFF80_0000, 1'b0, 1'b0, "1-inf");
        run_op(32'h0080_0001, 32'h0080_0000, 1'b1, 32'h0000_0000, 1'b0, 1'b0, "flush");
        run_op(32'h3F80_0000, 32'h3F80_0000, 1'b0, 32'h4000_0000, 1'b1, 1'b0, "hold start");
        run_op(32'h40A0_0000, 32'h4040_0000, 1'b0, 32'h4100_0000, 1'b0, 1'b1, "pulse b3");

        abort_op(4'd6, "abort B2");
        run_op(32'h3F80_0000, 32'h4000_0000, 1'b0, 32'h4040_0000, 1'b0, 1'b0, "after rst B2");
        abort_op(4'd11, "abort O2");
        run_op(32'h40A0_0000, 32'h4040_0000, 1'b1, 32'h4000_0000, 1'b0, 1'b0, "after rst O2");

        check("queue empty", 32'(exp_q.size()), 32'd0);

        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule
